// File: rtl/arm_controller_pkg.sv
// arm_controller_pkg
// Shared encodings for the ARM-subset control unit: instruction classes,
// ALU operation select, data-processing command codes, condition codes and
// extended-immediate formats.
package arm_controller_pkg;

  // Instruction class from Instr[27:26]
  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ImmSrc encodings
  localparam logic [1:0] IMM_ROT8  = 2'b00;
  localparam logic [1:0] IMM_12    = 2'b01;
  localparam logic [1:0] IMM_BR24  = 2'b10;

  // Condition field
  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/arm_condlogic.sv
// arm_condlogic
// Holds the NZCV flags (two independently enabled halves) and evaluates the
// condition field against them, gating every architectural side effect.
// Ports:
//   clk, reset         clock, async active-high reset (clears flags)
//   Cond[3:0]          instruction condition field
//   ALUFlags[3:0]      {N,Z,C,V} from the current ALU result
//   FlagW[1:0]         [1] update N,Z  [0] update C,V
//   PCS, RegW, MemW    ungated side-effect requests from the decoder
//   PCSrc, RegWrite, MemWrite  condition-gated side effects
module arm_condlogic
  import arm_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [1:0] nz;
  logic [1:0] cv;
  logic       condex;

  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond_e'(cond))
      CC_EQ:   cond_check = z;
      CC_NE:   cond_check = ~z;
      CC_CS:   cond_check = c;
      CC_CC:   cond_check = ~c;
      CC_MI:   cond_check = n;
      CC_PL:   cond_check = ~n;
      CC_VS:   cond_check = v;
      CC_VC:   cond_check = ~v;
      CC_HI:   cond_check = c & ~z;
      CC_LS:   cond_check = ~c | z;
      CC_GE:   cond_check = (n == v);
      CC_LT:   cond_check = (n != v);
      CC_GT:   cond_check = ~z & (n == v);
      CC_LE:   cond_check = z | (n != v);
      CC_AL:   cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  // Evaluated on the flags held before the edge, so an instruction never
  // sees the flags it produces itself.
  assign condex = cond_check(Cond, {nz, cv});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz <= 2'b00;
      cv <= 2'b00;
    end else begin
      if (FlagW[1] & condex) nz <= ALUFlags[3:2];
      if (FlagW[0] & condex) cv <= ALUFlags[1:0];
    end
  end

  assign PCSrc    = PCS  & condex;
  assign RegWrite = RegW & condex;
  assign MemWrite = MemW & condex;

endmodule

// File: rtl/arm_controller.sv
// arm_controller
// Control unit of the single-cycle ARM-subset processor (DP, LDR/STR, B).
// Decodes Instr[31:12] into datapath controls; flag storage and condition
// gating live in arm_condlogic.
// Ports:
//   clk, reset   clock and async active-high reset (flags only)
//   Instr[19:0]  instruction bits [31:12]
//   ALUFlags     {N,Z,C,V} from the current ALU result
//   RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg   ungated controls
//   RegWrite, MemWrite, PCSrc                      condition-gated controls
module arm_controller
  import arm_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        PCSrc
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       regw, memw, branch, aluop, pcs;
  logic [1:0] flagw;

  assign cond  = Instr[19:16];
  assign op    = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd    = Instr[3:0];
  assign cmd   = funct[4:1];

  // Main decode
  always_comb begin
    RegSrc   = 2'b00;
    ImmSrc   = IMM_ROT8;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    regw     = 1'b0;
    memw     = 1'b0;
    branch   = 1'b0;
    aluop    = 1'b0;
    case (op_e'(op))
      OP_DP: begin
        ALUSrc = funct[5];
        regw   = 1'b1;
        aluop  = 1'b1;
      end
      OP_MEM: begin
        ImmSrc = IMM_12;
        ALUSrc = 1'b1;
        if (funct[0]) begin
          MemtoReg = 1'b1;
          regw     = 1'b1;
        end else begin
          RegSrc = 2'b10;
          memw   = 1'b1;
        end
      end
      OP_BR: begin
        RegSrc = 2'b01;
        ImmSrc = IMM_BR24;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode; unknown commands fall back to ADD and never touch flags
  always_comb begin
    ALUControl = ALU_ADD;
    flagw      = 2'b00;
    if (aluop) begin
      case (cmd)
        CMD_ADD: begin ALUControl = ALU_ADD; flagw = {funct[0], funct[0]}; end
        CMD_SUB: begin ALUControl = ALU_SUB; flagw = {funct[0], funct[0]}; end
        CMD_AND: begin ALUControl = ALU_AND; flagw = {funct[0], 1'b0};     end
        CMD_ORR: begin ALUControl = ALU_ORR; flagw = {funct[0], 1'b0};     end
        default: begin ALUControl = ALU_ADD; flagw = 2'b00;                end
      endcase
    end
  end

  // Writing R15 is a jump just like a branch
  assign pcs = branch | (regw & (rd == 4'hF));

  arm_condlogic u_condlogic (
    .clk      (clk),
    .reset    (reset),
    .Cond     (cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flagw),
    .PCS      (pcs),
    .RegW     (regw),
    .MemW     (memw),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

endmodule

// File: tb/tb_arm_controller.sv
// tb_arm_controller
// Scoreboard bench: the stimulus process predicts each instruction's control
// outputs from an instruction-level model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_arm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemWrite;
  logic        MemtoReg;
  logic        PCSrc;

  always #5 clk = ~clk;

  arm_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc)
  );

  typedef struct packed {
    logic [10:0] outs;  // {RegSrc,ImmSrc,ALUSrc,ALUControl,MemtoReg,RegWrite,MemWrite,PCSrc}
    logic [1:0]  fw;    // {write NZ, write CV}
    logic        pass;
  } exp_t;

  logic [10:0] expq[$];
  int          idq[$];
  int          nid = 0;
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  mflags;   // model NZCV

  // Instruction-level reference: what the instruction means architecturally.
  function automatic exp_t model(input logic [19:0] ins, input logic [3:0] f);
    exp_t e;
    logic [3:0] cond = ins[19:16];
    logic [1:0] op   = ins[15:14];
    logic [5:0] fn   = ins[13:8];
    logic [3:0] rd   = ins[3:0];
    logic n = f[3], z = f[2], c = f[1], v = f[0];
    logic pass;
    logic [1:0] regsrc = 0, immsrc = 0, aluc = 0, fw = 0;
    logic alusrc = 0, m2r = 0, rw = 0, mw = 0, br = 0, pcs;
    case (cond)
      0: pass = z;          1: pass = !z;
      2: pass = c;          3: pass = !c;
      4: pass = n;          5: pass = !n;
      6: pass = v;          7: pass = !v;
      8: pass = c && !z;    9: pass = !c || z;
      10: pass = (n == v);  11: pass = (n != v);
      12: pass = !z && (n == v);
      13: pass = z || (n != v);
      14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    if (op == 0) begin
      rw = 1; alusrc = fn[5];
      if (fn[4:1] == 4)       begin aluc = 0; fw = {fn[0], fn[0]}; end
      else if (fn[4:1] == 2)  begin aluc = 1; fw = {fn[0], fn[0]}; end
      else if (fn[4:1] == 0)  begin aluc = 2; fw = {fn[0], 1'b0}; end
      else if (fn[4:1] == 12) begin aluc = 3; fw = {fn[0], 1'b0}; end
    end else if (op == 1) begin
      immsrc = 1; alusrc = 1;
      if (fn[0]) begin rw = 1; m2r = 1; end
      else begin mw = 1; regsrc = 2; end
    end else if (op == 2) begin
      regsrc = 1; immsrc = 2; alusrc = 1; br = 1;
    end
    pcs = br || (rw && rd == 15);
    e.outs = {regsrc, immsrc, alusrc, aluc, m2r, rw & pass, mw & pass, pcs & pass};
    e.fw   = fw;
    e.pass = pass;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input logic [19:0] ins, input logic [3:0] af);
    exp_t e;
    Instr    = ins;
    ALUFlags = af;
    if (reset) mflags = 4'b0000;
    e = model(ins, mflags);
    expq.push_back(e.outs);
    idq.push_back(nid);
    nid++;
    @(posedge clk);
    if (!reset && e.pass) begin
      if (e.fw[1]) mflags[3:2] = af[3:2];
      if (e.fw[0]) mflags[1:0] = af[1:0];
    end
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [10:0] got, exp;
      int id;
      exp = expq.pop_front();
      id  = idq.pop_front();
      got = {RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg, RegWrite, MemWrite, PCSrc};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ctrl#%0d instr=%05h got=%b exp=%b (RS,IS,AS,AC,M2R,RW,MW,PC)",
                 id, Instr, got, exp);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    mflags   = 4'h0;
    @(posedge clk); #1;
    apply(20'hE0865, 4'hF);          // during reset, AL still enabled
    reset = 1'b0;
    apply(20'hE0865, 4'hF);          // ADD, no S: flags untouched
    apply(20'h00865, 4'h0);          // ADDEQ on Z=0
    apply(20'hE0521, 4'b0100);       // SUBS -> Z
    apply(20'h00865, 4'h0);          // ADDEQ taken
    apply(20'hE0521, 4'b0000);       // SUBS -> clear
    apply(20'h00865, 4'h0);          // ADDEQ not taken
    apply(20'hE5921, 4'hF);          // LDR
    apply(20'hE5821, 4'hF);          // STR
    apply(20'hEA000, 4'hF);          // B
    apply(20'h0A000, 4'hF);          // BEQ, Z=0
    apply(20'hE081F, 4'hF);          // ADD R15
    apply(20'hE3800, 4'hF);          // ORR imm, no S
    apply(20'h00865, 4'h0);          // ADDEQ: Z still clear
    apply(20'hE0521, 4'b0100);       // SUBS -> Z
    reset = 1'b1;                    // mid-cycle, no edge
    apply(20'h00865, 4'h0);          // ADDEQ on cleared flags
    apply(20'h10865, 4'h0);          // ADDNE
    apply(20'hE0521, 4'b1111);       // SUBS during reset: ignored
    reset = 1'b0;
    apply(20'h10865, 4'h0);          // ADDNE still taken
    apply(20'h40865, 4'h0);          // ADDMI: N clear

    for (int i = 0; i < 400; i++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 2) == 0) ins[15:14] = 2'b00;
      if ($urandom_range(0, 7) == 0) ins[3:0]   = 4'hF;
      reset = ($urandom_range(0, 24) == 0);
      apply(ins, 4'($urandom));
    end
    reset = 1'b0;

    for (int k = 0; k < 5 && expq.size() > 0; k++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
